// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use 32-step shift-add and DIV/DIVU use 32-step restoring
// division on operand magnitudes. The sign fix-up is applied in FINISH.
// MTHI/MTLO write HI/LO directly from IDLE.
//
// state  | meaning
// IDLE   | waiting for start; MTHI/MTLO handled here
// RUN    | one multiply/divide iteration per cycle, counter 0..31
// FINISH | sign correction, HI/LO write, done pulse
module mult_div_unit #(
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(31);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [63:0]       acc;
  logic [31:0]       mag_a;      // multiplicand, or dividend bits still to shift in
  logic [31:0]       mag_b;      // multiplier (shifts right), or divisor
  logic [31:0]       raw_a;      // dividend as latched, returned in HI on divide by zero
  logic              is_div;
  logic              neg_q;      // product / quotient must be negated
  logic              neg_r;      // remainder must be negated
  logic              div_zero;

  logic              op_signed;
  logic [31:0]       abs_a;
  logic [31:0]       abs_b;
  logic [32:0]       mul_sum;
  logic [32:0]       div_r;
  logic              div_ge;
  logic [31:0]       div_diff;
  logic [63:0]       prod_fix;
  logic [31:0]       quo_fix;
  logic [31:0]       rem_fix;

  // Operand magnitudes, single-step datapath and final sign correction
  always_comb begin
    op_signed = ~op[0];
    abs_a     = (op_signed && operand_a[31]) ? (32'd0 - operand_a) : operand_a;
    abs_b     = (op_signed && operand_b[31]) ? (32'd0 - operand_b) : operand_b;
    mul_sum   = {1'b0, acc[63:32]} + (mag_b[0] ? {1'b0, mag_a} : 33'd0);
    div_r     = {acc[63:32], mag_a[31]};
    div_ge    = (div_r >= {1'b0, mag_b});
    div_diff  = div_r[31:0] - mag_b;
    prod_fix  = neg_q ? (64'd0 - acc) : acc;
    quo_fix   = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
    rem_fix   = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
  end

  // Control FSM, iteration datapath and HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      raw_a    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                mag_a    <= abs_a;
                mag_b    <= abs_b;
                raw_a    <= operand_a;
                is_div   <= op[1];
                neg_q    <= op_signed & (operand_a[31] ^ operand_b[31]);
                neg_r    <= op_signed & op[1] & operand_a[31];
                div_zero <= op[1] & (operand_b == 32'd0);
                acc      <= '0;
                cnt      <= '0;
                busy     <= 1'b1;
                state    <= RUN;
              end
              OP_MTHI: hi <= operand_a;
              OP_MTLO: lo <= operand_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (is_div) begin
            mag_a <= {mag_a[30:0], 1'b0};
            acc   <= {(div_ge ? div_diff : div_r[31:0]), acc[30:0], div_ge};
          end else begin
            mag_b <= {1'b0, mag_b[31:1]};
            acc   <= {mul_sum, acc[31:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= FINISH;
        end
        FINISH: begin
          if (!is_div) begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end else if (div_zero) begin
            hi <= raw_a;
            lo <= 32'hFFFF_FFFF;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] hi_m, lo_m;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  mult_div_unit #(.CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference results from plain integer arithmetic
  task automatic model(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rh, output logic [31:0] rl);
    logic [63:0] p;
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    rh = hi_m;
    rl = lo_m;
    case (mop)
      3'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
        rh = p[63:32]; rl = p[31:0];
      end
      3'd1: begin
        p  = {32'd0, a} * {32'd0, b};
        rh = p[63:32]; rl = p[31:0];
      end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          rh = a; rl = 32'hFFFF_FFFF;
        end else if (mop == 3'd2) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q  = sa / sb;
          r  = sa % sb;
          qv = 64'(q); rv = 64'(r);
          rl = qv[31:0]; rh = rv[31:0];
        end else begin
          rl = a / b; rh = a % b;
        end
      end
      3'd4: rh = a;
      3'd5: rl = a;
      default: ;
    endcase
  endtask

  // Issue one MULT/DIV op; optional start pulse injected while busy
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int inject);
    int busy_cnt;
    bit got;
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0; operand_a = $urandom; operand_b = $urandom;
    busy_cnt = 0; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (done) got = 1;
      else begin
        if (busy) busy_cnt++;
        if (i == inject) begin
          start = 1'b1; op = 3'd2; operand_a = 32'd100; operand_b = 32'd0;
        end else begin
          start = 1'b0; operand_a = $urandom; operand_b = $urandom;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    check({name, " done_seen"}, 32'(got), 32'd1);
    check({name, " busy_cycles"}, busy_cnt, 33);
    check({name, " busy_at_done"}, 32'(busy), 32'd0);
    check({name, " hi"}, hi, eh);
    check({name, " lo"}, lo, el);
    @(negedge clk);
    check({name, " done_one_cycle"}, 32'(done), 32'd0);
    hi_m = eh; lo_m = el;
  endtask

  task automatic run_mt(input string name, input logic [2:0] o, input logic [31:0] a);
    logic [31:0] eh, el;
    model(o, a, 32'd0, eh, el);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = $urandom;
    @(negedge clk);
    start = 1'b0;
    check({name, " hi"}, hi, eh);
    check({name, " lo"}, lo, el);
    check({name, " busy"}, 32'(busy), 32'd0);
    check({name, " done"}, 32'(done), 32'd0);
    hi_m = eh; lo_m = el;
  endtask

  vec_t vecs[$];

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb, eh, el;
    bit          saw_done;

    vecs.push_back('{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg"});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"});
    vecs.push_back('{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg"});
    vecs.push_back('{3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, "divu"});
    vecs.push_back('{3'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, "divu_zero"});
    vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf"});
    vecs.push_back('{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_negb"});
    vecs.push_back('{3'd2, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, "div_zero_s"});

    rst = 1'b1; start = 1'b0; op = 3'd0; operand_a = '0; operand_b = '0;
    hi_m = '0; lo_m = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, -1);

    // start while busy must be ignored
    run_op("busy_ignore", 3'd1, 32'd3, 32'd5, 32'd0, 32'd15, 4);

    run_mt("mthi", 3'd4, 32'hCAFE_F00D);
    run_mt("mtlo", 3'd5, 32'h1234_5678);
    run_mt("nop6", 3'd6, 32'hDEAD_BEEF);
    run_mt("nop7", 3'd7, 32'hBEEF_DEAD);

    // reset in the middle of a MULT
    @(negedge clk);
    start = 1'b1; op = 3'd0; operand_a = 32'h1234_5678; operand_b = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst hi", hi, 32'd0);
    check("midrst lo", lo, 32'd0);
    hi_m = '0; lo_m = '0;
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) saw_done = 1;
      @(negedge clk);
    end
    check("midrst no_activity", 32'(saw_done), 32'd0);
    run_op("mult_after_rst", 3'd0, 32'd2, 32'd3, 32'd0, 32'd6, -1);

    // random ops against the reference model
    for (int k = 0; k < 24; k++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 28);
      model(ro, ra, rb, eh, el);
      run_op($sformatf("rand%0d_op%0d", k, ro), ro, ra, rb, eh, el, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
